clk_period_monitor: RTL

CLK_PERIOD_MONITOR -- requirements
Module: clk_period_monitor

---
 rtl/clkmon_pkg.sv | 21 ++
 rtl/clkmon_sync2.sv | 33 +++
 rtl/clk_period_monitor.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/clkmon_pkg.sv
// Shared definitions for the clock period monitor: FSM state encoding,
// default parameter values and the tolerance-window compare helper.
package clkmon_pkg;

   localparam int CNT_W  = 8;
   localparam int EXP_LO = 6;
   localparam int EXP_HI = 4;
   localparam int TOL    = 0;

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } clkmon_state_e;

   // True when meas lies inside [expv - tol, expv + tol]; signed math avoids underflow.
   function automatic logic in_tol(input int meas, input int expv, input int tol);
      return (meas >= (expv - tol)) && (meas <= (expv + tol));
   endfunction

endpackage

// File: rtl/clkmon_sync2.sv
// Two-flop synchronizer for the monitored clock, cleared by the monitor reset.
module clkmon_sync2 (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic meta_d;
   logic sync_q;
   logic sync_d;

   // Next-state: shift the asynchronous input through two stages.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer flops, forced low by the asynchronous clear.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Clock period monitor: measures the low and high phase lengths of mon_clk
// in clk cycles, flags out-of-tolerance phases and a stuck monitored clock.
// Build option: define CLKMON_SYNC_EN to insert a 2-flop synchronizer in
// front of the sampling flop (counts unchanged, latency +2 cycles).
module clk_period_monitor
   import clkmon_pkg::*;
#(
   parameter int CNT_W  = clkmon_pkg::CNT_W,
   parameter int EXP_LO = clkmon_pkg::EXP_LO,
   parameter int EXP_HI = clkmon_pkg::EXP_HI,
   parameter int TOL    = clkmon_pkg::TOL
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             mon_clk,
   input  logic             err_clr,
   output logic [CNT_W-1:0] lo_cnt,
   output logic [CNT_W-1:0] hi_cnt,
   output logic             valid,
   output logic             err,
   output logic             stuck
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic mon_in;

`ifdef CLKMON_SYNC_EN
   clkmon_sync2 u_sync (
      .clk (clk),
      .clr (clr),
      .d   (mon_clk),
      .q   (mon_in)
   );
`else
   assign mon_in = mon_clk;
`endif

   logic             s_q, s_d;
   logic             prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   clkmon_state_e    state_q, state_d;
   logic             lo_seen_q, lo_seen_d;
   logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             stuck_q, stuck_d;

   logic rise_s, fall_s, edge_s, sat_s, cmp_fail_s;

   // Next-state logic: edge detect, run counter, phase FSM and flags.
   always_comb begin
      rise_s = s_q & ~prev_q;
      fall_s = ~s_q & prev_q;
      edge_s = rise_s | fall_s;

      s_d    = mon_in;
      prev_d = s_q;

      if (edge_s) begin
         cnt_d = CNT_ONE;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = CNT_MAX;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end

      // Saturation is an event: the cycle the counter first reaches its ceiling.
      sat_s = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);

      state_d    = state_q;
      lo_seen_d  = lo_seen_q;
      lo_cnt_d   = lo_cnt_q;
      hi_cnt_d   = hi_cnt_q;
      valid_d    = 1'b0;
      cmp_fail_s = 1'b0;

      if (edge_s) begin
         stuck_d = 1'b0;
      end else begin
         stuck_d = stuck_q;
      end

      case (state_q)
         HUNT: begin
            // First edge only aligns to the waveform; the partial phase is dropped.
            if (rise_s) begin
               state_d = HIGH;
            end else if (fall_s) begin
               state_d = LOW;
            end else begin
               state_d = HUNT;
            end
         end
         LOW: begin
            if (rise_s) begin
               lo_cnt_d   = cnt_q;
               cmp_fail_s = ~in_tol(int'(cnt_q), EXP_LO, TOL);
               lo_seen_d  = 1'b1;
               state_d    = HIGH;
            end else begin
               state_d = LOW;
            end
         end
         HIGH: begin
            if (fall_s) begin
               hi_cnt_d   = cnt_q;
               cmp_fail_s = ~in_tol(int'(cnt_q), EXP_HI, TOL);
               valid_d    = lo_seen_q;
               state_d    = LOW;
            end else begin
               state_d = HIGH;
            end
         end
         default: begin
            state_d = HUNT;
         end
      endcase

      if (sat_s) begin
         stuck_d   = 1'b1;
         lo_seen_d = 1'b0;
         state_d   = HUNT;
      end else begin
         stuck_d = stuck_d;
      end

      // A new error in the same cycle as err_clr wins.
      if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
      if (cmp_fail_s || sat_s) begin
         err_d = 1'b1;
      end else begin
         err_d = err_d;
      end
   end

   // State and registered outputs, all cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         s_q       <= 1'b0;
         prev_q    <= 1'b0;
         cnt_q     <= {CNT_W{1'b0}};
         state_q   <= HUNT;
         lo_seen_q <= 1'b0;
         lo_cnt_q  <= {CNT_W{1'b0}};
         hi_cnt_q  <= {CNT_W{1'b0}};
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         stuck_q   <= 1'b0;
      end else begin
         s_q       <= s_d;
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         lo_seen_q <= lo_seen_d;
         lo_cnt_q  <= lo_cnt_d;
         hi_cnt_q  <= hi_cnt_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         stuck_q   <= stuck_d;
      end
   end

   assign lo_cnt = lo_cnt_q;
   assign hi_cnt = hi_cnt_q;
   assign valid  = valid_q;
   assign err    = err_q;
   assign stuck  = stuck_q;

endmodule
